// File: rtl/ascon_pack.sv
// Shared Ascon definitions: padding constants, rate size and the
// state encoding used by the data feeder.
package ascon_pack;

    localparam logic [7:0]  ASCON_PAD_BYTE   = 8'h80;
    localparam int          ASCON_RATE_BYTES = 8;
    localparam logic [63:0] ASCON_PAD_BLOCK  = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PRESENT,
        PAD_ONLY
    } type_feeder_state;

endpackage

// File: rtl/ascon_pad_buffer.sv
// Byte-indexed 64-bit block register with byte/pad writes and a fill counter.
// Ports: clock_i/resetb_i, clear_i, wr_byte_i, wr_pad_i, byte_i -> data_o, cnt_o.
module ascon_pad_buffer
    import ascon_pack::*;
(
    input  logic        clock_i,
    input  logic        resetb_i,
    input  logic        clear_i,
    input  logic        wr_byte_i,
    input  logic        wr_pad_i,
    input  logic [7:0]  byte_i,
    output logic [63:0] data_o,
    output logic [3:0]  cnt_o
);

    logic [63:0] r_data;
    logic [3:0]  r_cnt;
    logic [63:0] w_data;
    logic [3:0]  w_cnt;
    logic [3:0]  w_cnt_inc;

    assign w_cnt_inc = r_cnt + 4'd1;

    // Pad byte lands one slot after the byte written this cycle;
    // slots beyond it stay zero because the buffer is cleared first.
    always_comb begin
        w_data = r_data;
        w_cnt  = r_cnt;
        if (clear_i) begin
            w_data = '0;
            w_cnt  = '0;
        end else if (wr_byte_i) begin
            for (int i = 0; i < ASCON_RATE_BYTES; i++) begin
                if (r_cnt == 4'(i))
                    w_data[63-8*i -: 8] = byte_i;
                if (wr_pad_i && w_cnt_inc == 4'(i))
                    w_data[63-8*i -: 8] = ASCON_PAD_BYTE;
            end
            w_cnt = w_cnt_inc;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else begin
            r_data <= w_data;
            r_cnt  <= w_cnt;
        end
    end

    assign data_o = r_data;
    assign cnt_o  = r_cnt;

endmodule

// File: rtl/ascon_data_feeder.sv
// Packs a byte stream into padded 64-bit big-endian blocks for the Ascon core.
// Ports: start/empty control, byte valid/ready input, data/valid/last/nb to core, ack, busy.
module ascon_data_feeder
    import ascon_pack::*;
#(
    parameter int BLOCK_BYTES = 8
) (
    input  logic        clock_i,
    input  logic        resetb_i,
    input  logic        start_i,
    input  logic        empty_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    input  logic        byte_last_i,
    output logic        byte_ready_o,
    output logic [63:0] data_o,
    output logic        data_valid_o,
    output logic        data_last_o,
    output logic [3:0]  nb_bytes_o,
    input  logic        data_ack_i,
    output logic        busy_o
);

    type_feeder_state r_state;
    type_feeder_state w_state;

    logic        r_pad_pending;
    logic        r_last;
    logic [3:0]  r_nb;
    logic        w_pad_pending;
    logic        w_last;
    logic [3:0]  w_nb;

    logic        w_clear;
    logic        w_wr_byte;
    logic        w_wr_pad;
    logic        w_xfer;
    logic        w_final_slot;
    logic [63:0] w_buf;
    logic [3:0]  w_cnt;

    ascon_pad_buffer u_buf (
        .clock_i   (clock_i),
        .resetb_i  (resetb_i),
        .clear_i   (w_clear),
        .wr_byte_i (w_wr_byte),
        .wr_pad_i  (w_wr_pad),
        .byte_i    (byte_i),
        .data_o    (w_buf),
        .cnt_o     (w_cnt)
    );

    assign w_xfer       = byte_valid_i && (r_state == FILL);
    assign w_final_slot = (w_cnt == 4'(BLOCK_BYTES - 1));

    always_comb begin
        w_state       = r_state;
        w_pad_pending = r_pad_pending;
        w_last        = r_last;
        w_nb          = r_nb;
        w_clear       = 1'b0;
        w_wr_byte     = 1'b0;
        w_wr_pad      = 1'b0;
        if (start_i) begin
            // Restart wins over any same-cycle ack or byte transfer.
            w_clear       = 1'b1;
            w_pad_pending = 1'b0;
            w_last        = 1'b0;
            w_nb          = '0;
            w_state       = empty_i ? PAD_ONLY : FILL;
        end else begin
            unique case (r_state)
                IDLE: begin
                end
                FILL: begin
                    if (w_xfer) begin
                        w_wr_byte = 1'b1;
                        if (w_final_slot) begin
                            // Full block; a last byte here needs a
                            // separate pad-only block afterwards.
                            w_state       = PRESENT;
                            w_last        = 1'b0;
                            w_nb          = 4'(BLOCK_BYTES);
                            w_pad_pending = byte_last_i;
                        end else if (byte_last_i) begin
                            w_wr_pad = 1'b1;
                            w_state  = PRESENT;
                            w_last   = 1'b1;
                            w_nb     = w_cnt + 4'd1;
                        end
                    end
                end
                PRESENT: begin
                    if (data_ack_i) begin
                        if (r_pad_pending) begin
                            w_state       = PAD_ONLY;
                            w_pad_pending = 1'b0;
                        end else if (r_last) begin
                            w_state = IDLE;
                        end else begin
                            w_state = FILL;
                            w_clear = 1'b1;
                        end
                    end
                end
                PAD_ONLY: begin
                    if (data_ack_i)
                        w_state = IDLE;
                end
                default: w_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state       <= IDLE;
            r_pad_pending <= 1'b0;
            r_last        <= 1'b0;
            r_nb          <= '0;
        end else begin
            r_state       <= w_state;
            r_pad_pending <= w_pad_pending;
            r_last        <= w_last;
            r_nb          <= w_nb;
        end
    end

    always_comb begin
        byte_ready_o = (r_state == FILL);
        data_valid_o = (r_state == PRESENT) || (r_state == PAD_ONLY);
        data_o       = (r_state == PAD_ONLY) ? ASCON_PAD_BLOCK : w_buf;
        data_last_o  = (r_state == PRESENT) ? r_last : (r_state == PAD_ONLY);
        nb_bytes_o   = (r_state == PRESENT) ? r_nb : 4'd0;
        busy_o       = (r_state != IDLE);
    end

endmodule
